// File: rtl/coco_sector_parser.sv
// coco_sector_parser
//   Parses the fields that follow the CoCo FM address marks. An ID field (track, side,
//   sector, size, CRC) is latched and, while it is still within its pairing window, a
//   following data or deleted-data field is streamed out byte by byte with its index.
//   CRC-16/CCITT (poly 0x1021, preset 0xFFFF) is run over the mark byte and all field
//   bytes, so a good field leaves a residue of zero.
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   enable                       low parks the parser in idle and drops any latched ID
//   am_id/am_data/am_deleted     1-clk address-mark strobes (priority in that order)
//   byte_in/byte_valid           decoded field byte and its strobe
//   id_*                         last ID field contents; id_valid pulses on completion
//   data_out/data_valid/index    payload stream, CRC bytes not emitted
//   sector_*                     data field completion status
//   err_timeout/abort/orphan     1-clk error pulses
module coco_sector_parser #(
  parameter int unsigned MAX_LEN_CODE   = 3,
  parameter int unsigned ID_WINDOW_CLKS = 65536,
  parameter int unsigned TIMEOUT_CLKS   = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       am_id,
  input  logic       am_data,
  input  logic       am_deleted,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       id_valid,
  output logic [7:0] id_track,
  output logic [7:0] id_side,
  output logic [7:0] id_sector,
  output logic [7:0] id_size,
  output logic       id_crc_ok,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [9:0] data_index,
  output logic       sector_done,
  output logic       sector_crc_ok,
  output logic       sector_deleted,
  output logic       err_timeout,
  output logic       err_abort,
  output logic       err_orphan
);

  localparam int unsigned WinW = $clog2(ID_WINDOW_CLKS + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [1:0]  MaxCode = (MAX_LEN_CODE > 3) ? 2'd3 : 2'(MAX_LEN_CODE);

  typedef enum logic [1:0] {StIdle, StId, StData} state_e;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [10:0]      cnt_q, cnt_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [ToW-1:0]   to_q, to_d;
  logic             latched_q, latched_d;
  logic             del_q, del_d;
  logic [7:0]       track_q, track_d, side_q, side_d, sector_q, sector_d, size_q, size_d;
  logic             id_valid_q, id_valid_d, id_crc_ok_q, id_crc_ok_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic [9:0]       data_index_q, data_index_d;
  logic             done_q, done_d, sec_ok_q, sec_ok_d, sec_del_q, sec_del_d;
  logic             e_to_q, e_to_d, e_ab_q, e_ab_d, e_or_q, e_or_d;

  logic        am_any;
  logic [1:0]  len_code;
  logic [10:0] data_len;
  logic [15:0] crc_next;

  assign am_any   = am_id | am_data | am_deleted;
  assign len_code = (size_q[1:0] > MaxCode) ? MaxCode : size_q[1:0];
  assign data_len = 11'd128 << len_code;
  assign crc_next = crc_step(crc_q, byte_in);

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    to_d         = to_q;
    latched_d    = latched_q;
    del_d        = del_q;
    track_d      = track_q;
    side_d       = side_q;
    sector_d     = sector_q;
    size_d       = size_q;
    id_valid_d   = 1'b0;
    id_crc_ok_d  = id_crc_ok_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    data_index_d = data_index_q;
    done_d       = 1'b0;
    sec_ok_d     = sec_ok_q;
    sec_del_d    = sec_del_q;
    e_to_d       = 1'b0;
    e_ab_d       = 1'b0;
    e_or_d       = 1'b0;

    if (!enable) begin
      state_d   = StIdle;
      latched_d = 1'b0;
      crc_d     = 16'hFFFF;
      cnt_d     = '0;
      win_d     = '0;
      to_d      = '0;
    end else begin
      // Pairing window ages every clock; an expired window drops the ID.
      if (latched_q) begin
        if (win_q != '0) win_d = win_q - 1'b1;
        if (win_q <= WinW'(1)) latched_d = 1'b0;
      end

      if (am_any) begin
        // A mark always restarts parsing; any byte in the same clock is the mark itself.
        if (state_q != StIdle) e_ab_d = 1'b1;
        state_d = StIdle;
        crc_d   = 16'hFFFF;
        cnt_d   = '0;
        to_d    = ToW'(TIMEOUT_CLKS);
        if (am_id) begin
          state_d = StId;
          crc_d   = crc_step(16'hFFFF, 8'hFE);
        end else if (latched_q) begin
          state_d = StData;
          del_d   = ~am_data;
          crc_d   = crc_step(16'hFFFF, am_data ? 8'hFB : 8'hF8);
        end else begin
          e_or_d = 1'b1;
        end
      end else if (state_q != StIdle) begin
        if (byte_valid) begin
          crc_d = crc_next;
          cnt_d = cnt_q + 11'd1;
          to_d  = ToW'(TIMEOUT_CLKS);
          if (state_q == StId) begin
            case (cnt_q[2:0])
              3'd0:    track_d  = byte_in;
              3'd1:    side_d   = byte_in;
              3'd2:    sector_d = byte_in;
              3'd3:    size_d   = byte_in;
              default: ;
            endcase
            if (cnt_q == 11'd5) begin
              state_d     = StIdle;
              id_valid_d  = 1'b1;
              id_crc_ok_d = (crc_next == 16'h0000);
              latched_d   = (crc_next == 16'h0000);
              if (crc_next == 16'h0000) win_d = WinW'(ID_WINDOW_CLKS);
            end
          end else begin
            if (cnt_q < data_len) begin
              data_out_d   = byte_in;
              data_valid_d = 1'b1;
              data_index_d = cnt_q[9:0];
            end
            if (cnt_q == data_len + 11'd1) begin
              state_d   = StIdle;
              done_d    = 1'b1;
              sec_ok_d  = (crc_next == 16'h0000);
              sec_del_d = del_q;
              latched_d = 1'b0;
            end
          end
        end else if (to_q <= ToW'(1)) begin
          state_d   = StIdle;
          e_to_d    = 1'b1;
          latched_d = 1'b0;
        end else begin
          to_d = to_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      crc_q        <= 16'hFFFF;
      cnt_q        <= '0;
      win_q        <= '0;
      to_q         <= '0;
      latched_q    <= 1'b0;
      del_q        <= 1'b0;
      track_q      <= '0;
      side_q       <= '0;
      sector_q     <= '0;
      size_q       <= '0;
      id_valid_q   <= 1'b0;
      id_crc_ok_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_index_q <= '0;
      done_q       <= 1'b0;
      sec_ok_q     <= 1'b0;
      sec_del_q    <= 1'b0;
      e_to_q       <= 1'b0;
      e_ab_q       <= 1'b0;
      e_or_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      to_q         <= to_d;
      latched_q    <= latched_d;
      del_q        <= del_d;
      track_q      <= track_d;
      side_q       <= side_d;
      sector_q     <= sector_d;
      size_q       <= size_d;
      id_valid_q   <= id_valid_d;
      id_crc_ok_q  <= id_crc_ok_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_index_q <= data_index_d;
      done_q       <= done_d;
      sec_ok_q     <= sec_ok_d;
      sec_del_q    <= sec_del_d;
      e_to_q       <= e_to_d;
      e_ab_q       <= e_ab_d;
      e_or_q       <= e_or_d;
    end
  end

  assign id_valid       = id_valid_q;
  assign id_track       = track_q;
  assign id_side        = side_q;
  assign id_sector      = sector_q;
  assign id_size        = size_q;
  assign id_crc_ok      = id_crc_ok_q;
  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign data_index     = data_index_q;
  assign sector_done    = done_q;
  assign sector_crc_ok  = sec_ok_q;
  assign sector_deleted = sec_del_q;
  assign err_timeout    = e_to_q;
  assign err_abort      = e_ab_q;
  assign err_orphan     = e_or_q;

endmodule

// File: tb/tb_coco_sector_parser.sv
// Directed bench for coco_sector_parser: ID parsing, data streaming, CRC status,
// orphan/abort/timeout errors, enable and asynchronous reset behaviour.
module tb_coco_sector_parser;

  localparam int unsigned TimeoutClks = 4096;

  logic       clk, reset_n, enable;
  logic       am_id, am_data, am_deleted;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       id_valid, id_crc_ok;
  logic [7:0] id_track, id_side, id_sector, id_size;
  logic [7:0] data_out;
  logic       data_valid;
  logic [9:0] data_index;
  logic       sector_done, sector_crc_ok, sector_deleted;
  logic       err_timeout, err_abort, err_orphan;

  coco_sector_parser #(
    .MAX_LEN_CODE  (3),
    .ID_WINDOW_CLKS(65536),
    .TIMEOUT_CLKS  (TimeoutClks)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .am_id         (am_id),
    .am_data       (am_data),
    .am_deleted    (am_deleted),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .id_valid      (id_valid),
    .id_track      (id_track),
    .id_side       (id_side),
    .id_sector     (id_sector),
    .id_size       (id_size),
    .id_crc_ok     (id_crc_ok),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_index    (data_index),
    .sector_done   (sector_done),
    .sector_crc_ok (sector_crc_ok),
    .sector_deleted(sector_deleted),
    .err_timeout   (err_timeout),
    .err_abort     (err_abort),
    .err_orphan    (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Byte-wise CCITT update (shift/xor form, independent of the bitwise loop).
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = {8'h00, c[15:8] ^ b};
    x = x ^ (x >> 4);
    return (c << 8) ^ (x << 12) ^ (x << 5) ^ x;
  endfunction

  // Pulse counters and payload-order tracking, sampled away from the active edge.
  int dv_cnt, idx_err, done_cnt, abort_cnt, orphan_cnt;
  always @(negedge clk) begin
    if (data_valid) begin
      if (data_index != 10'(dv_cnt) || data_out != 8'(dv_cnt)) idx_err++;
      dv_cnt++;
    end
    if (sector_done) done_cnt++;
    if (err_abort)   abort_cnt++;
    if (err_orphan)  orphan_cnt++;
  end

  task automatic clear_counts();
    dv_cnt = 0; idx_err = 0; done_cnt = 0; abort_cnt = 0; orphan_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = ID, 1 = data, 2 = deleted data
  task automatic strobe(input int kind);
    am_id      = (kind == 0);
    am_data    = (kind == 1);
    am_deleted = (kind == 2);
    tick();
    am_id = 1'b0; am_data = 1'b0; am_deleted = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_id(input logic [7:0] t, input logic [7:0] s, input logic [7:0] r,
                         input logic [7:0] n, input logic bad);
    logic [7:0]  f [4];
    logic [15:0] c;
    f = '{t, s, r, n};
    strobe(0);
    c = crc_upd(16'hFFFF, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      send_byte(f[i]);
      c = crc_upd(c, f[i]);
    end
    send_byte(c[15:8]);
    send_byte(c[7:0] ^ {7'd0, bad});
  endtask

  // Sends n payload bytes (value = index); CRC follows only when n is the full length.
  task automatic send_data(input logic del, input int n, input int len, input logic bad);
    logic [15:0] c;
    strobe(del ? 2 : 1);
    c = crc_upd(16'hFFFF, del ? 8'hF8 : 8'hFB);
    for (int k = 0; k < n; k++) begin
      send_byte(8'(k));
      c = crc_upd(c, 8'(k));
    end
    if (n == len) begin
      send_byte(c[15:8] ^ {bad, 7'd0});
      send_byte(c[7:0]);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {5'd0, id_valid, id_track, id_side, id_sector, id_size, id_crc_ok, data_out,
            data_valid, data_index, sector_done, sector_crc_ok, sector_deleted,
            err_timeout, err_abort, err_orphan};
  endfunction

  initial begin
    int waited;
    reset_n = 1'b0; enable = 1'b1;
    am_id = 1'b0; am_data = 1'b0; am_deleted = 1'b0;
    byte_in = 8'h00; byte_valid = 1'b0;
    clear_counts();
    repeat (3) tick();
    check("reset_outputs", all_outs(), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: good ID
    send_id(8'h11, 8'h00, 8'h05, 8'h01, 1'b0);
    check("id_valid", {63'd0, id_valid}, 64'd1);
    check("id_track", {56'd0, id_track}, 64'h11);
    check("id_side", {56'd0, id_side}, 64'h00);
    check("id_sector", {56'd0, id_sector}, 64'h05);
    check("id_size", {56'd0, id_size}, 64'h01);
    check("id_crc_ok", {63'd0, id_crc_ok}, 64'd1);
    tick();
    check("id_valid_one_clk", {63'd0, id_valid}, 64'd0);

    // 2: 256-byte data field
    clear_counts();
    send_data(1'b0, 256, 256, 1'b0);
    check("sec_done", {63'd0, sector_done}, 64'd1);
    check("sec_crc_ok", {63'd0, sector_crc_ok}, 64'd1);
    check("sec_deleted", {63'd0, sector_deleted}, 64'd0);
    check("dv_count", 64'(dv_cnt), 64'd256);
    check("dv_order", 64'(idx_err), 64'd0);
    strobe(1);
    check("orphan_after_done", {63'd0, err_orphan}, 64'd1);

    // 3: bad ID CRC, then orphan data mark
    send_id(8'h11, 8'h00, 8'h05, 8'h01, 1'b1);
    check("bad_id_valid", {63'd0, id_valid}, 64'd1);
    check("bad_id_crc_ok", {63'd0, id_crc_ok}, 64'd0);
    clear_counts();
    strobe(1);
    check("orphan_bad_id", {63'd0, err_orphan}, 64'd1);
    repeat (4) send_byte(8'hAA);
    check("orphan_no_data", 64'(dv_cnt), 64'd0);

    // 4: deleted mark, bad data CRC
    send_id(8'h03, 8'h00, 8'h01, 8'h01, 1'b0);
    send_data(1'b1, 256, 256, 1'b1);
    check("del_done", {63'd0, sector_done}, 64'd1);
    check("del_flag", {63'd0, sector_deleted}, 64'd1);
    check("del_crc_ok", {63'd0, sector_crc_ok}, 64'd0);

    // 5: abort a data field with a new ID mark
    send_id(8'h11, 8'h00, 8'h05, 8'h01, 1'b0);
    clear_counts();
    send_data(1'b0, 100, 256, 1'b0);
    send_id(8'h22, 8'h01, 8'h09, 8'h01, 1'b0);
    check("abort_count", 64'(abort_cnt), 64'd1);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_dv_count", 64'(dv_cnt), 64'd100);
    check("new_id", {32'd0, id_track, id_side, id_sector, id_size}, 64'h22010901);
    check("new_id_ok", {62'd0, id_valid, id_crc_ok}, 64'd3);

    // Enable low drops the latched ID
    enable = 1'b0;
    tick();
    enable = 1'b1;
    strobe(1);
    check("enable_clears_id", {63'd0, err_orphan}, 64'd1);

    // 6: byte timeout
    send_id(8'h11, 8'h00, 8'h05, 8'h01, 1'b0);
    send_data(1'b0, 10, 256, 1'b0);
    waited = 0;
    while (waited < TimeoutClks + 20 && !err_timeout) begin
      tick();
      waited++;
    end
    check("timeout_seen", {63'd0, err_timeout}, 64'd1);
    check("timeout_delay", 64'(waited), 64'(TimeoutClks));
    strobe(1);
    check("timeout_clears_id", {63'd0, err_orphan}, 64'd1);

    // Asynchronous reset mid-field
    send_id(8'h11, 8'h00, 8'h05, 8'h01, 1'b0);
    send_data(1'b0, 5, 256, 1'b0);
    check("pre_reset_dv", {63'd0, data_valid}, 64'd1);
    #1 reset_n = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
